// File: rtl/alu_issue_arbiter.sv
// Issue arbiter sharing one ALU among NREQ requesters: X (execute) and W (writeback/CDB) stages.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module alu_issue_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_op1,
  input  logic [NREQ*WIDTH-1:0]   req_op2,
  input  logic [NREQ*4-1:0]       req_func,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic [WIDTH-1:0]        alu_op1,
  output logic [WIDTH-1:0]        alu_op2,
  output logic [3:0]              alu_func,
  input  logic [WIDTH-1:0]        alu_out,
  output logic                    cdb_valid,
  input  logic                    cdb_ready,
  output logic [WIDTH-1:0]        cdb_data,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [IDX_W-1:0]        cdb_src
);

  localparam int unsigned CW = IDX_W + 1;

  logic             w_accept, x_accept, gnt_any, gnt_fire;
  logic [IDX_W-1:0] gnt_idx, start_idx;
  logic [CW-1:0]    cand;

  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] x_op1_q, x_op1_d, x_op2_q, x_op2_d;
  logic [3:0]       x_func_q, x_func_d;
  logic [TAG_W-1:0] x_tag_q, x_tag_d;
  logic [IDX_W-1:0] x_src_q, x_src_d;

  logic             w_valid_q, w_valid_d;
  logic [WIDTH-1:0] w_data_q, w_data_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;
  logic [IDX_W-1:0] w_src_q, w_src_d;

  assign w_accept = ~w_valid_q | cdb_ready;
  assign x_accept = ~x_valid_q | w_accept;
  assign gnt_fire = gnt_any & x_accept & ~flush;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_fire) ptr_d = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  // Circular search from start_idx; the fold keeps cand below NREQ for non-power-of-two NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, start_idx} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!gnt_any && req_valid[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_fire) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    x_valid_d = x_valid_q;
    x_op1_d   = x_op1_q;
    x_op2_d   = x_op2_q;
    x_func_d  = x_func_q;
    x_tag_d   = x_tag_q;
    x_src_d   = x_src_q;
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    w_tag_d   = w_tag_q;
    w_src_d   = w_src_q;
    if (flush) begin
      x_valid_d = 1'b0;
      w_valid_d = 1'b0;
    end else begin
      if (x_accept) begin
        x_valid_d = gnt_any;
        if (gnt_any) begin
          x_op1_d  = req_op1[gnt_idx*WIDTH +: WIDTH];
          x_op2_d  = req_op2[gnt_idx*WIDTH +: WIDTH];
          x_func_d = req_func[gnt_idx*4 +: 4];
          x_tag_d  = req_tag[gnt_idx*TAG_W +: TAG_W];
          x_src_d  = gnt_idx;
        end
      end
      // W payload only reloads on a real op so bubbles leave cdb_* untouched.
      if (w_accept) begin
        w_valid_d = x_valid_q;
        if (x_valid_q) begin
          w_data_d = alu_out;
          w_tag_d  = x_tag_q;
          w_src_d  = x_src_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_q <= 1'b0;
      x_op1_q   <= '0;
      x_op2_q   <= '0;
      x_func_q  <= '0;
      x_tag_q   <= '0;
      x_src_q   <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_tag_q   <= '0;
      w_src_q   <= '0;
    end else begin
      x_valid_q <= x_valid_d;
      x_op1_q   <= x_op1_d;
      x_op2_q   <= x_op2_d;
      x_func_q  <= x_func_d;
      x_tag_q   <= x_tag_d;
      x_src_q   <= x_src_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_tag_q   <= w_tag_d;
      w_src_q   <= w_src_d;
    end
  end

  assign alu_op1   = x_valid_q ? x_op1_q  : '0;
  assign alu_op2   = x_valid_q ? x_op2_q  : '0;
  assign alu_func  = x_valid_q ? x_func_q : '0;

  assign cdb_valid = w_valid_q;
  assign cdb_data  = w_data_q;
  assign cdb_tag   = w_tag_q;
  assign cdb_src   = w_src_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: slot-level reference model checked every cycle, plus directed literal checks.
module tb_alu_issue_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int TAG_W = 6;
  localparam int IDX_W = 2;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;

  logic                  clk, rst_n, flush, cdb_ready, cdb_valid;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_op1, req_op2;
  logic [NREQ*4-1:0]     req_func;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [WIDTH-1:0]      alu_op1, alu_op2, alu_out, cdb_data;
  logic [3:0]            alu_func;
  logic [TAG_W-1:0]      cdb_tag;
  logic [IDX_W-1:0]      cdb_src;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_func(req_func), .req_tag(req_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .alu_out(alu_out),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] f, input logic [WIDTH-1:0] a, b);
    case (f)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_func, alu_op1, alu_op2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which requester the arbitration rule picks, or -1 if none is valid.
  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (start + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: one slot per stage; results computed when the op moves to writeback.
  bit               mx_v = 1'b0, mw_v = 1'b0;
  int               mptr = 0, mx_src = 0, mw_src = 0;
  logic [WIDTH-1:0] mx_op1, mx_op2, mw_data;
  logic [3:0]       mx_func;
  logic [TAG_W-1:0] mx_tag, mw_tag;

  always @(posedge clk or negedge rst_n) begin
    bit m_wacc, m_xacc;
    int m_g;
    if (!rst_n) begin
      mx_v = 1'b0; mw_v = 1'b0; mptr = 0;
    end else begin
      m_wacc = !mw_v || cdb_ready;
      m_xacc = !mx_v || m_wacc;
      m_g    = pick(req_valid, mptr);
      if (flush) begin
        mx_v = 1'b0; mw_v = 1'b0;
      end else begin
        if (m_wacc) begin
          if (mx_v) begin
            mw_data = alu_ref(mx_func, mx_op1, mx_op2);
            mw_tag  = mx_tag;
            mw_src  = mx_src;
          end
          mw_v = mx_v;
        end
        if (m_xacc) begin
          mx_v = (m_g >= 0);
          if (m_g >= 0) begin
            mx_op1  = req_op1[m_g*WIDTH +: WIDTH];
            mx_op2  = req_op2[m_g*WIDTH +: WIDTH];
            mx_func = req_func[m_g*4 +: 4];
            mx_tag  = req_tag[m_g*TAG_W +: TAG_W];
            mx_src  = m_g;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            mptr = (m_g + 1) % NREQ;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit c_wacc, c_xacc;
    int c_g;
    logic [NREQ-1:0] c_ready;
    c_wacc  = !mw_v || cdb_ready;
    c_xacc  = !mx_v || c_wacc;
    c_g     = pick(req_valid, mptr);
    c_ready = '0;
    if (c_xacc && !flush && c_g >= 0) c_ready[c_g] = 1'b1;
    chk("model_req_ready", req_ready, c_ready);
    chk("model_cdb_valid", cdb_valid, mw_v);
    if (mw_v) begin
      chk("model_cdb_data", cdb_data, mw_data);
      chk("model_cdb_tag", cdb_tag, mw_tag);
      chk("model_cdb_src", cdb_src, mw_src);
    end
    chk("model_alu_op1", alu_op1, mx_v ? mx_op1 : '0);
    chk("model_alu_op2", alu_op2, mx_v ? mx_op2 : '0);
    chk("model_alu_func", alu_func, mx_v ? mx_func : 4'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, b, input logic [3:0] f,
                         input logic [TAG_W-1:0] t);
    req_op1[i*WIDTH +: WIDTH] = a;
    req_op2[i*WIDTH +: WIDTH] = b;
    req_func[i*4 +: 4]        = f;
    req_tag[i*TAG_W +: TAG_W] = t;
  endtask

  // Check the grant, let the edge take it, then the granted requester drops valid.
  task automatic grant_step(input string nm, input logic [NREQ-1:0] exp);
    logic [NREQ-1:0] g;
    at_neg();
    chk(nm, req_ready, exp);
    g = req_ready;
    tick();
    req_valid = req_valid & ~g;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] seq3 [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    seq3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    seq3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1; req_valid = '0;
    req_op1 = '0; req_op2 = '0; req_func = '0; req_tag = '0;
    tick(); tick();
    at_neg();
    chk("reset_cdb_valid", cdb_valid, 1'b0);
    chk("reset_cdb_data", cdb_data, 32'h0);
    chk("reset_alu_func", alu_func, 4'h0);
    chk("reset_req_ready", req_ready, 4'b0000);
    tick();
    rst_n = 1'b1;

    // Single request, ADD 5+3, tag 9 from requester 2.
    set_req(2, 32'd5, 32'd3, OP_ADD, 6'd9);
    req_valid = 4'b0100;
    grant_step("t1_grant", 4'b0100);
    at_neg();
    chk("t1_x_cdb_valid", cdb_valid, 1'b0);
    chk("t1_alu_op1", alu_op1, 32'd5);
    chk("t1_alu_func", alu_func, OP_ADD);
    tick();
    at_neg();
    chk("t1_cdb_valid", cdb_valid, 1'b1);
    chk("t1_cdb_data", cdb_data, 32'd8);
    chk("t1_cdb_tag", cdb_tag, 6'd9);
    chk("t1_cdb_src", cdb_src, 2'd2);
    tick();

    // SUB 0-1 wraps; SLTU 1<2 gives 1.
    set_req(0, 32'd0, 32'd1, OP_SUB, 6'd1);
    set_req(1, 32'd1, 32'd2, OP_SLTU, 6'd2);
    req_valid = 4'b0011;
    grant_step("t2_grant0", 4'b0001);
    grant_step("t2_grant1", 4'b0010);
    at_neg();
    chk("t2_sub_data", cdb_data, 32'hFFFF_FFFF);
    chk("t2_sub_src", cdb_src, 2'd0);
    tick();
    at_neg();
    chk("t2_sltu_data", cdb_data, 32'd1);
    chk("t2_sltu_tag", cdb_tag, 6'd2);
    tick(); tick();

    // All four valid continuously at full throughput.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'(i + 100), OP_ADD, 6'(20 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk($sformatf("t3_grant%0d", k), req_ready, seq3[k]);
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // CDB stall: single bubble fill, hold, then in-order drain.
    do_reset();
    set_req(0, 32'd10, 32'd20, OP_ADD, 6'd10);
    set_req(1, 32'd50, 32'd8, OP_SUB, 6'd11);
    set_req(2, 32'hF0, 32'hFF, OP_XOR, 6'd12);
    req_valid = 4'b0001;
    grant_step("t4_grant0", 4'b0001);
    cdb_ready = 1'b0;
    req_valid = '0;
    tick();
    req_valid = 4'b0110;
    grant_step("t4_bubble", 4'b0010);
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("t4_stall_ready", req_ready, 4'b0000);
      chk("t4_hold_data", cdb_data, 32'd30);
      chk("t4_hold_tag", cdb_tag, 6'd10);
      tick();
    end
    cdb_ready = 1'b1;
    grant_step("t4_resume", 4'b0100);
    at_neg();
    chk("t4_drain1", cdb_data, 32'd42);
    chk("t4_drain1_tag", cdb_tag, 6'd11);
    tick();
    at_neg();
    chk("t4_drain2", cdb_data, 32'h0F);
    chk("t4_drain2_tag", cdb_tag, 6'd12);
    tick(); tick();

    // Flush with both stages full.
    set_req(0, 32'd1, 32'd1, OP_ADD, 6'd30);
    set_req(1, 32'd2, 32'd2, OP_ADD, 6'd31);
    set_req(3, 32'd3, 32'd3, OP_ADD, 6'd33);
    cdb_ready = 1'b0;
    req_valid = 4'b0011;
    grant_step("t5_grant0", 4'b0001);
    grant_step("t5_grant1", 4'b0010);
    flush = 1'b1; cdb_ready = 1'b1; req_valid = 4'b1001;
    at_neg();
    chk("t5_flush_ready", req_ready, 4'b0000);
    chk("t5_flush_cdb_valid", cdb_valid, 1'b1);
    tick();
    flush = 1'b0;
    at_neg();
    chk("t5_after_cdb_valid", cdb_valid, 1'b0);
    chk("t5_after_alu_func", alu_func, 4'h0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    chk("t5_after_grant", req_ready, 4'b1000);
`else
    chk("t5_after_grant", req_ready, 4'b0001);
`endif
    tick();
    req_valid = '0;
    tick(); tick(); tick();

    // Asynchronous reset mid-stall.
    set_req(0, 32'd7, 32'd7, OP_ADD, 6'd40);
    set_req(1, 32'd8, 32'd8, OP_ADD, 6'd41);
    cdb_ready = 1'b0;
    req_valid = 4'b0011;
    grant_step("t6_grant0", 4'b0001);
    grant_step("t6_grant1", 4'b0010);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_cdb_valid", cdb_valid, 1'b0);
    chk("t6_rst_cdb_data", cdb_data, 32'h0);
    chk("t6_rst_cdb_tag", cdb_tag, 6'h0);
    chk("t6_rst_cdb_src", cdb_src, 2'h0);
    chk("t6_rst_alu_op1", alu_op1, 32'h0);
    chk("t6_rst_alu_func", alu_func, 4'h0);
    req_valid = 4'b1111;
    tick();
    rst_n = 1'b1;
    at_neg();
    chk("t6_resume_grant", req_ready, 4'b0001);
    cdb_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares one combinational ALU among NREQ issue requesters (reservation-station ports) in the OoO backend. Each cycle it grants at most one valid request, registers its operands, function code and tag into an execute stage that drives the ALU, and captures the ALU result into a writeback register presented to the common data bus (CDB) with valid/ready backpressure. It is a two-stage pipeline with throughput of one operation per cycle when the CDB does not stall.

## Interface
- WIDTH, 32, operand/result width
- NREQ, 4, number of requesters (2..8)
- TAG_W, 6, destination tag width
- IDX_W, $clog2(NREQ), requester index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- flush  in  1  synchronous pipeline kill (mispredict recovery)
- req_valid  in  NREQ  request valid per requester
- req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready
- req_op1, req_op2  in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
- req_func  in  NREQ*4  ALU function code, existing ALU_OP_* encoding
- req_tag  in  NREQ*TAG_W  destination tag
- alu_op1, alu_op2  out  WIDTH  to ALU, straight from execute-stage registers
- alu_func  out  4  to ALU, from execute-stage register
- alu_out  in  WIDTH  ALU result, combinational from the above
- cdb_valid  out  1  writeback entry valid
- cdb_ready  in  1  CDB accepts entry
- cdb_data  out  WIDTH  result
- cdb_tag  out  TAG_W  destination tag
- cdb_src  out  IDX_W  index of requester that issued it

## Operation
- Stages: X (execute regs x_valid, x_op1, x_op2, x_func, x_tag, x_src) and W (w_valid, w_data, w_tag, w_src).
- w_accept = !w_valid | cdb_ready; x_accept = !x_valid | w_accept.
- Grant: when x_accept & !flush, exactly one req_ready bit set for a selected valid requester; none if no req_valid. req_ready all-zero when !x_accept or flush.
- On grant edge: X loads the granted requester's fields, x_valid=1. If x_accept and no grant, x_valid=0.
- On w_accept edge: W loads alu_out, x_tag, x_src; w_valid=x_valid.
- cdb_valid=w_valid; cdb_data/tag/src hold stable while cdb_valid&!cdb_ready.
- alu_func driven 4'b0 and operands 0 when x_valid=0 (no spurious toggling).
- flush: next edge x_valid=0, w_valid=0; no grant that cycle; arbitration pointer unchanged. Flush overrides cdb_ready (entry dropped even if accepted same cycle is not allowed: cdb_valid still asserted that cycle, consumer must honour flush).
- Requesters must hold valid and fields stable until granted; the block does not check this.

## Timing
- Reset (rst_n low, async): x_valid=0, w_valid=0, all data regs 0, arbitration pointer 0; thus req_ready=0 only if no req_valid — ready resumes first cycle after release.
- Latency: grant at edge k -> cdb_valid high after edge k+1 (result visible two cycles after the request first appears unstalled).
- Full-throughput: back-to-back grants every cycle while cdb_ready=1.
- Stall: cdb_ready=0 with W and X full -> req_ready=0 all; X and W hold.
- Single-bubble: W full, X empty, cdb_ready=0 -> one grant still allowed (fills X).
- Reset asserted mid-operation discards both stages immediately.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: pointer register; search starts at pointer, wrapping modulo NREQ; on grant to i, pointer <= (i+1) mod NREQ. Pointer only moves on an actual grant.
- Not defined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Single request: req_valid=4'b0100, op1=5, op2=3, func=ADD, tag=9 -> req_ready=4'b0100 one cycle, next cycle cdb_valid=1, data=8, tag=9, src=2.
- All four valid continuously, cdb_ready=1, RR enabled -> grants 0,1,2,3,0 in consecutive cycles; fixed priority -> grants 0 every cycle.
- CDB stall: 3 back-to-back issues, cdb_ready=0 after first enters W -> exactly one more grant, then req_ready=0; W data held; on cdb_ready=1 results drain in issue order.
- Flush with both stages full -> next cycle cdb_valid=0, no grant during flush cycle, pointer unchanged.
- SUB 0-1 (WIDTH=32) -> cdb_data=32'hFFFFFFFF; SLTU 1<2 -> 1.
- rst_n pulsed low mid-stall -> cdb_valid drops immediately, all outputs 0, grant resumes at index 0.
